// File: rtl/systolic_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : systolic_pkg
//  Purpose  : Shared definitions for the systolic cluster feeder: the feeder
//             state enumeration, the default MAC pipeline depth and the Q1.15
//             saturation limits.
//  Revision : 1.0  initial release
// ============================================================================
package systolic_pkg;

  // Default PE multiply pipeline depth; sets the length of the drain phase.
  localparam int MAC_LATENCY = 2;

  // Q1.15 saturation limits.
  localparam logic signed [15:0] Q15_MAX = 16'sh7FFF;
  localparam logic signed [15:0] Q15_MIN = 16'sh8000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_LOAD  = 3'd2,
    ST_FEED  = 3'd3,
    ST_FLUSH = 3'd4,
    ST_DRAIN = 3'd5,
    ST_DONE  = 3'd6
  } feeder_state_e;

endpackage
`default_nettype wire

// File: rtl/systolic_cluster_feeder_if.sv
`default_nettype none
// ============================================================================
//  Module   : systolic_cluster_feeder_if
//  Purpose  : Bundles the command, weight-stream, activation-stream and
//             cluster-control signals of the feeder.
//  Ports    : master - command/stream source (drives cmd_*, w_*, a_* data
//                      and valids; observes everything else)
//             slave  - the feeder itself
//  Revision : 1.0  initial release
// ============================================================================
interface systolic_cluster_feeder_if #(
  parameter int DATA_BITS  = 16,
  parameter int ARRAY_SIZE = 8,
  parameter int NUM_ARRAYS = 8,
  parameter int K_BITS     = 8
);
  localparam int SEL_BITS  = $clog2(NUM_ARRAYS);
  localparam int LANE_BITS = ARRAY_SIZE * DATA_BITS;

  // Tile command
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [SEL_BITS-1:0]  cmd_array;
  logic                 cmd_broadcast;
  logic [K_BITS-1:0]    cmd_k_len;
  // Weight-row stream
  logic                 w_valid;
  logic                 w_ready;
  logic [LANE_BITS-1:0] w_data;
  // Activation stream
  logic                 a_valid;
  logic                 a_ready;
  logic [LANE_BITS-1:0] a_data;
  // Cluster controls
  logic                 cl_enable;
  logic [SEL_BITS-1:0]  cl_array_select;
  logic                 cl_broadcast;
  logic                 cl_clear_acc;
  logic                 cl_load_weights;
  logic                 cl_compute_enable;
  logic [LANE_BITS-1:0] cl_a_inputs;
  logic [LANE_BITS-1:0] cl_b_inputs;
  // Status
  logic                 busy;
  logic                 done;

  modport master (
    output cmd_valid, cmd_array, cmd_broadcast, cmd_k_len,
    output w_valid, w_data, a_valid, a_data,
    input  cmd_ready, w_ready, a_ready,
    input  cl_enable, cl_array_select, cl_broadcast, cl_clear_acc,
    input  cl_load_weights, cl_compute_enable, cl_a_inputs, cl_b_inputs,
    input  busy, done
  );

  modport slave (
    input  cmd_valid, cmd_array, cmd_broadcast, cmd_k_len,
    input  w_valid, w_data, a_valid, a_data,
    output cmd_ready, w_ready, a_ready,
    output cl_enable, cl_array_select, cl_broadcast, cl_clear_acc,
    output cl_load_weights, cl_compute_enable, cl_a_inputs, cl_b_inputs,
    output busy, done
  );

endinterface
`default_nettype wire

// File: rtl/systolic_cluster_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : systolic_cluster_feeder
//  Purpose  : Upstream sequencer for a systolic array cluster. Accepts one
//             tile command, then clears accumulators, loads N weight rows,
//             streams K activation vectors, flushes and drains the pipeline
//             and pulses done. Missing stream data stalls the cluster by
//             dropping cl_enable.
//  Ports    : clk      - clock
//             reset_n  - asynchronous reset, active low
//             bus      - slave side of systolic_cluster_feeder_if (command,
//                        weight/activation streams, cluster controls, status)
//  Revision : 1.0  initial release
// ============================================================================
module systolic_cluster_feeder #(
  parameter int DATA_BITS   = 16,
  parameter int ARRAY_SIZE  = 8,
  parameter int NUM_ARRAYS  = 8,
  parameter int K_BITS      = 8,
  parameter int MAC_LATENCY = systolic_pkg::MAC_LATENCY
) (
  input  wire logic                clk,
  input  wire logic                reset_n,
  systolic_cluster_feeder_if.slave bus
);
  import systolic_pkg::*;

  localparam int SEL_BITS  = $clog2(NUM_ARRAYS);
  localparam int CNT_BITS  = $clog2(ARRAY_SIZE) + 1;
  localparam int LANE_BITS = ARRAY_SIZE * DATA_BITS;

  localparam logic [CNT_BITS-1:0] c_load_init  = CNT_BITS'(ARRAY_SIZE - 1);
  localparam logic [CNT_BITS-1:0] c_flush_init = CNT_BITS'(ARRAY_SIZE - 2);
  localparam logic [CNT_BITS-1:0] c_drain_init = CNT_BITS'(MAC_LATENCY - 1);

  feeder_state_e       state_q,     state_d;
  // Shared down-counter: remaining LOAD rows, FLUSH cycles or DRAIN cycles.
  logic [CNT_BITS-1:0] cnt_q,       cnt_d;
  logic [K_BITS-1:0]   feed_cnt_q,  feed_cnt_d;
  logic [K_BITS-1:0]   k_len_q,     k_len_d;
  logic [SEL_BITS-1:0] array_sel_q, array_sel_d;
  logic                broadcast_q, broadcast_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      feed_cnt_q  <= '0;
      k_len_q     <= '0;
      array_sel_q <= '0;
      broadcast_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      feed_cnt_q  <= feed_cnt_d;
      k_len_q     <= k_len_d;
      array_sel_q <= array_sel_d;
      broadcast_q <= broadcast_d;
    end
  end

  always_comb begin
    state_d               = state_q;
    cnt_d                 = cnt_q;
    feed_cnt_d            = feed_cnt_q;
    k_len_d               = k_len_q;
    array_sel_d           = array_sel_q;
    broadcast_d           = broadcast_q;

    bus.cmd_ready         = 1'b0;
    bus.w_ready           = 1'b0;
    bus.a_ready           = 1'b0;
    bus.cl_enable         = 1'b0;
    bus.cl_clear_acc      = 1'b0;
    bus.cl_load_weights   = 1'b0;
    bus.cl_compute_enable = 1'b0;
    bus.cl_a_inputs       = '0;
    bus.cl_b_inputs       = '0;
    bus.done              = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        bus.cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          array_sel_d = bus.cmd_array;
          broadcast_d = bus.cmd_broadcast;
          k_len_d     = bus.cmd_k_len;
          state_d     = ST_CLEAR;
        end
      end

      ST_CLEAR: begin
        bus.cl_enable    = 1'b1;
        bus.cl_clear_acc = 1'b1;
        cnt_d            = c_load_init;
        feed_cnt_d       = '0;
        state_d          = ST_LOAD;
      end

      ST_LOAD: begin
        bus.w_ready         = 1'b1;
        bus.cl_load_weights = 1'b1;
        bus.cl_b_inputs     = bus.w_data;
        bus.cl_enable       = bus.w_valid;
        if (bus.w_valid) begin
          if (cnt_q == '0) begin
            // An empty tile still has to push the cleared state through.
            if (k_len_q == '0) begin
              cnt_d   = c_flush_init;
              state_d = ST_FLUSH;
            end else begin
              state_d = ST_FEED;
            end
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end

      ST_FEED: begin
        bus.a_ready           = 1'b1;
        bus.cl_compute_enable = 1'b1;
        bus.cl_a_inputs       = bus.a_data;
        bus.cl_enable         = bus.a_valid;
        if (bus.a_valid) begin
          if (feed_cnt_q == k_len_q - K_BITS'(1)) begin
            cnt_d   = c_flush_init;
            state_d = ST_FLUSH;
          end else begin
            feed_cnt_d = feed_cnt_q + 1'b1;
          end
        end
      end

      ST_FLUSH: begin
        // Zero lanes ripple the last vector through the remaining columns.
        bus.cl_enable         = 1'b1;
        bus.cl_compute_enable = 1'b1;
        if (cnt_q == '0) begin
          cnt_d   = c_drain_init;
          state_d = ST_DRAIN;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      ST_DRAIN: begin
        bus.cl_enable = 1'b1;
        if (cnt_q == '0) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      ST_DONE: begin
        bus.done = 1'b1;
        state_d  = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Selection stays on the finished tile until the next command is taken.
  assign bus.cl_array_select = array_sel_q;
  assign bus.cl_broadcast    = broadcast_q;
  assign bus.busy            = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_systolic_cluster_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_systolic_cluster_feeder
//  Purpose  : Self-checking bench for systolic_cluster_feeder (N=4, 4 arrays).
//             Expected per-cycle outputs come from a tile model that walks
//             the phase list clear / N rows / K vectors / N-1 flush /
//             drain / done and counts accepted transfers.
//  Revision : 1.0  initial release
// ============================================================================
module tb_systolic_cluster_feeder;
  import systolic_pkg::*;

  localparam int N    = 4;
  localparam int DB   = 16;
  localparam int NA   = 4;
  localparam int KB   = 8;
  localparam int ML   = 2;
  localparam int LW   = N * DB;

  logic clk;
  logic reset_n;

  systolic_cluster_feeder_if #(
    .DATA_BITS(DB), .ARRAY_SIZE(N), .NUM_ARRAYS(NA), .K_BITS(KB)
  ) ifc ();

  systolic_cluster_feeder #(
    .DATA_BITS(DB), .ARRAY_SIZE(N), .NUM_ARRAYS(NA), .K_BITS(KB), .MAC_LATENCY(ML)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic          cmd_ready;
    logic          busy;
    logic          done;
    logic          en;
    logic          clr;
    logic          ld;
    logic          cmp;
    logic          w_rdy;
    logic          a_rdy;
    logic [1:0]    sel;
    logic          bc;
    logic [LW-1:0] a;
    logic [LW-1:0] b;
  } obs_t;

  typedef struct {
    logic [1:0] arr;
    logic       bc;
    int         k;
    int         pat;          // 0 random, 1 all 0x4000, 2 weight order, 3 a=0xC000, 4 a=Q15_MIN
    int         w_stall_at;   // row index before which w_valid drops
    int         w_stall_len;
    int         a_stall_at;   // vector index before which a_valid drops
    int         a_stall_len;
    bit         hold_cmd;     // keep offering a different command while busy
    int         exp_done;     // cycle of done after the accept edge (0 = derive)
  } vec_t;

  int checks = 0;
  int passes = 0;
  logic [1:0] cur_sel = '0;
  logic       cur_bc  = 1'b0;

  function automatic logic [LW-1:0] fill(input logic [DB-1:0] x);
    return {N{x}};
  endfunction

  function automatic logic [LW-1:0] rnd_lanes();
    return {$urandom, $urandom};
  endfunction

  function automatic obs_t observe();
    obs_t o;
    o.cmd_ready = ifc.cmd_ready;
    o.busy      = ifc.busy;
    o.done      = ifc.done;
    o.en        = ifc.cl_enable;
    o.clr       = ifc.cl_clear_acc;
    o.ld        = ifc.cl_load_weights;
    o.cmp       = ifc.cl_compute_enable;
    o.w_rdy     = ifc.w_ready;
    o.a_rdy     = ifc.a_ready;
    o.sel       = ifc.cl_array_select;
    o.bc        = ifc.cl_broadcast;
    o.a         = ifc.cl_a_inputs;
    o.b         = ifc.cl_b_inputs;
    return o;
  endfunction

  function automatic obs_t idle_exp();
    obs_t e = '0;
    e.cmd_ready = 1'b1;
    e.sel       = cur_sel;
    e.bc        = cur_bc;
    return e;
  endfunction

  function automatic obs_t busy_exp();
    obs_t e = '0;
    e.busy = 1'b1;
    e.sel  = cur_sel;
    e.bc   = cur_bc;
    return e;
  endfunction

  task automatic check_obs(input string name, input obs_t e);
    obs_t g;
    g = observe();
    checks++;
    if (g === e) passes++;
    else $display("FAIL %s t=%0t: got %h required %h", name, $time, g, e);
  endtask

  task automatic check_int(input string name, input int got, input int req);
    checks++;
    if (got == req) passes++;
    else $display("FAIL %s: got %0d required %0d", name, got, req);
  endtask

  // Start of a tile cycle: inputs are changed right after the falling edge.
  task automatic begin_cycle(input vec_t v, input bit hold);
    @(negedge clk);
    ifc.cmd_valid     = hold;
    ifc.cmd_array     = ~v.arr;
    ifc.cmd_broadcast = ~v.bc;
    ifc.cmd_k_len     = 8'd1;
    ifc.w_valid       = 1'b0;
    ifc.a_valid       = 1'b0;
    ifc.w_data        = rnd_lanes();
    ifc.a_data        = rnd_lanes();
  endtask

  function automatic logic [LW-1:0] w_row(input int pat, input int j);
    case (pat)
      0:       return rnd_lanes();
      2:       return fill(16'(32'h0100 * (N - j)));
      default: return fill(16'h4000);
    endcase
  endfunction

  function automatic logic [LW-1:0] a_vec(input int pat);
    case (pat)
      0:       return rnd_lanes();
      1:       return fill(16'h4000);
      2:       return fill(Q15_MAX);
      3:       return fill(16'hC000);
      default: return fill(Q15_MIN);
    endcase
  endfunction

  task automatic run_tile(input string tag, input vec_t v, input int pct);
    obs_t e;
    int cyc, rows, vecs, wst, ast, stalls, streak;
    bit ok;

    // Accept cycle in IDLE
    @(negedge clk);
    ifc.cmd_valid     = 1'b1;
    ifc.cmd_array     = v.arr;
    ifc.cmd_broadcast = v.bc;
    ifc.cmd_k_len     = KB'(v.k);
    ifc.w_valid       = 1'b0;
    ifc.a_valid       = 1'b0;
    ifc.w_data        = rnd_lanes();
    ifc.a_data        = rnd_lanes();
    #1;
    check_obs({tag, ":accept"}, idle_exp());
    cur_sel = v.arr;
    cur_bc  = v.bc;
    cyc = 0; stalls = 0; wst = 0; ast = 0;

    // CLEAR
    begin_cycle(v, v.hold_cmd); cyc++; #1;
    e = busy_exp(); e.en = 1'b1; e.clr = 1'b1;
    check_obs({tag, ":clear"}, e);

    // LOAD: N accepted rows
    rows = 0; streak = 0;
    while (rows < N) begin
      begin_cycle(v, v.hold_cmd); cyc++;
      ok = 1'b1;
      if (rows == v.w_stall_at && wst < v.w_stall_len) begin ok = 1'b0; wst++; end
      else if (pct > 0 && streak < 20 && $urandom_range(99) < pct) ok = 1'b0;
      ifc.w_valid = ok;
      ifc.w_data  = w_row(v.pat, rows);
      #1;
      e = busy_exp(); e.ld = 1'b1; e.w_rdy = 1'b1; e.en = ok; e.b = ifc.w_data;
      check_obs({tag, ":load"}, e);
      if (ok) begin rows++; streak = 0; end else begin stalls++; streak++; end
    end

    // FEED: k accepted vectors
    vecs = 0; streak = 0;
    while (vecs < v.k) begin
      begin_cycle(v, v.hold_cmd); cyc++;
      ok = 1'b1;
      if (vecs == v.a_stall_at && ast < v.a_stall_len) begin ok = 1'b0; ast++; end
      else if (pct > 0 && streak < 20 && $urandom_range(99) < pct) ok = 1'b0;
      ifc.a_valid = ok;
      ifc.a_data  = a_vec(v.pat);
      #1;
      e = busy_exp(); e.cmp = 1'b1; e.a_rdy = 1'b1; e.en = ok; e.a = ifc.a_data;
      check_obs({tag, ":feed"}, e);
      if (ok) begin vecs++; streak = 0; end else begin stalls++; streak++; end
    end

    // FLUSH: N-1 cycles, valids offered but never taken
    for (int i = 0; i < N - 1; i++) begin
      begin_cycle(v, v.hold_cmd); cyc++;
      ifc.w_valid = 1'b1; ifc.a_valid = 1'b1; #1;
      e = busy_exp(); e.en = 1'b1; e.cmp = 1'b1;
      check_obs({tag, ":flush"}, e);
    end

    // DRAIN
    for (int i = 0; i < ML; i++) begin
      begin_cycle(v, v.hold_cmd); cyc++;
      ifc.a_valid = 1'b1; #1;
      e = busy_exp(); e.en = 1'b1;
      check_obs({tag, ":drain"}, e);
    end

    // DONE
    begin_cycle(v, v.hold_cmd); cyc++; #1;
    e = busy_exp(); e.done = 1'b1;
    check_obs({tag, ":done"}, e);
    if (v.exp_done > 0) check_int({tag, ":done_cycle"}, cyc, v.exp_done);
    else check_int({tag, ":done_cycle"}, cyc, 1 + N + v.k + (N - 1) + ML + 1 + stalls);

    // Back in IDLE with the tile selection still held
    begin_cycle(v, 1'b0); #1;
    check_obs({tag, ":idle_after"}, idle_exp());
  endtask

  vec_t tbl[7];
  vec_t rv;

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    //            arr  bc    k  pat wsa wsl asa asl hold done
    tbl[0] = '{2'd2, 1'b0, 2, 1, 0,  0,  0,  0,  1'b0, 13};  // basic
    tbl[1] = '{2'd2, 1'b0, 4, 1, 0,  0,  0,  0,  1'b0, 15};  // saturation case
    tbl[2] = '{2'd1, 1'b0, 2, 3, 0,  0,  0,  0,  1'b0, 13};  // negative activations
    tbl[3] = '{2'd2, 1'b0, 2, 1, 2,  3,  1,  2,  1'b0, 18};  // stalls
    tbl[4] = '{2'd3, 1'b0, 1, 2, 0,  0,  0,  0,  1'b0, 12};  // weight order
    tbl[5] = '{2'd0, 1'b1, 0, 1, 0,  0,  0,  0,  1'b1, 11};  // broadcast, K=0
    tbl[6] = '{2'd1, 1'b1, 3, 4, 0,  0,  0,  0,  1'b1, 14};  // Q15_MIN lanes

    ifc.cmd_valid = 1'b0; ifc.cmd_array = '0; ifc.cmd_broadcast = 1'b0; ifc.cmd_k_len = '0;
    ifc.w_valid = 1'b0; ifc.w_data = '0; ifc.a_valid = 1'b0; ifc.a_data = '0;
    reset_n = 1'b1;

    // Reset state
    @(negedge clk); reset_n = 1'b0;
    ifc.w_valid = 1'b1; ifc.a_valid = 1'b1; ifc.w_data = rnd_lanes(); ifc.a_data = rnd_lanes();
    @(posedge clk); @(posedge clk); #1;
    check_obs("reset_state", idle_exp());
    @(negedge clk); reset_n = 1'b1; ifc.w_valid = 1'b0; ifc.a_valid = 1'b0;
    #1;
    check_obs("after_release", idle_exp());

    // Directed tiles
    for (int i = 0; i < 7; i++) run_tile($sformatf("tbl%0d", i), tbl[i], 0);

    // Reset in the middle of FEED (array 3, K=4)
    @(negedge clk);
    ifc.cmd_valid = 1'b1; ifc.cmd_array = 2'd3; ifc.cmd_broadcast = 1'b1; ifc.cmd_k_len = 8'd4;
    @(negedge clk); ifc.cmd_valid = 1'b0;                   // CLEAR
    for (int i = 0; i < N; i++) begin                        // LOAD
      @(negedge clk); ifc.w_valid = 1'b1; ifc.w_data = rnd_lanes();
    end
    @(negedge clk); ifc.w_valid = 1'b0; ifc.a_valid = 1'b1; ifc.a_data = rnd_lanes();
    @(negedge clk); ifc.a_data = rnd_lanes(); #1;            // second FEED cycle
    cur_sel = 2'd3; cur_bc = 1'b1;
    begin
      obs_t e;
      e = busy_exp(); e.cmp = 1'b1; e.a_rdy = 1'b1; e.en = 1'b1; e.a = ifc.a_data;
      check_obs("rst:feed_before", e);
    end
    #1 reset_n = 1'b0; #1;
    cur_sel = '0; cur_bc = 1'b0;
    check_obs("rst:async", idle_exp());
    @(posedge clk); #1;
    check_obs("rst:next_edge", idle_exp());
    @(negedge clk); reset_n = 1'b1; ifc.a_valid = 1'b0;
    run_tile("rst:next_tile", tbl[0], 0);

    // Randomized tiles with random stalls
    for (int t = 0; t < 25; t++) begin
      rv.arr = 2'($urandom_range(3));
      rv.bc = 1'($urandom_range(1));
      rv.k = int'($urandom_range(6));
      rv.pat = 0;
      rv.w_stall_at = 0; rv.w_stall_len = 0; rv.a_stall_at = 0; rv.a_stall_len = 0;
      rv.hold_cmd = 1'($urandom_range(1));
      rv.exp_done = 0;
      run_tile($sformatf("rand%0d", t), rv, 35);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
